// File: rtl/axi4_lite_register_responder_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
//   wr_state_e / rd_state_e : write and read FSM states
//   RESP_OKAY                : the only response this responder returns
//   idx_of()                 : byte address -> register index decode
//   merge_bytes()            : byte-strobe merge of new data over old data
// The helpers work on the widest legal buses; callers zero-extend their
// operands and slice the result back to their own widths.
package axi4_lite_register_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_EXEC = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_EXEC = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int DATA_MAX = 64;
    localparam int STRB_MAX = 8;
    localparam int ADDR_MAX = 64;
    localparam int IDX_MAX  = 16;

    // Register index = addr[lsb +: mw]; byte-offset bits below and any
    // bits above the index field are ignored.
    function automatic logic [IDX_MAX-1:0] idx_of(input logic [ADDR_MAX-1:0] addr,
                                                  input int lsb, input int mw);
        logic [ADDR_MAX-1:0] sh;
        logic [ADDR_MAX-1:0] mask;
        sh   = addr >> lsb;
        mask = (64'd1 << mw) - 64'd1;
        sh   = sh & mask;
        return sh[IDX_MAX-1:0];
    endfunction

    // Byte k comes from new_d when strb[k] is set, otherwise from old_d.
    function automatic logic [DATA_MAX-1:0] merge_bytes(input logic [DATA_MAX-1:0] new_d,
                                                        input logic [DATA_MAX-1:0] old_d,
                                                        input logic [STRB_MAX-1:0] strb);
        logic [DATA_MAX-1:0] r;
        for (int k = 0; k < STRB_MAX; k++) begin
            r[8*k +: 8] = strb[k] ? new_d[8*k +: 8] : old_d[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_lite_register_responder_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   N : data bus width in bytes,  A : address width
//   master modport : drives addresses, data, valids and bready/rready
//   slave  modport : drives readies, responses, bvalid/rvalid and rdata
interface axi4_lite_if #(
    parameter int N = 4,
    parameter int A = 32
);
    logic [A-1:0]   awaddr;
    logic           awvalid;
    logic           awready;
    logic [8*N-1:0] wdata_axi;
    logic [N-1:0]   wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [A-1:0]   araddr;
    logic           arvalid;
    logic           arready;
    logic [8*N-1:0] rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;

    modport master (
        output awaddr, awvalid, wdata_axi, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata_axi, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_register_responder_wr_merge.sv
// Combinational byte-strobe merge used on register write paths.
//   new_data : incoming write data       old_data : current register value
//   strb     : per-byte select           merged   : strobe-merged result
module axi4_lite_register_wr_merge
    import axi4_lite_register_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [8*N-1:0] new_data,
    input  logic [8*N-1:0] old_data,
    input  logic [N-1:0]   strb,
    output logic [8*N-1:0] merged
);
    logic [DATA_MAX-1:0] n64;
    logic [DATA_MAX-1:0] o64;
    logic [DATA_MAX-1:0] m64;
    logic [STRB_MAX-1:0] s8;

    always_comb begin
        n64 = '0;
        o64 = '0;
        s8  = '0;
        n64[8*N-1:0] = new_data;
        o64[8*N-1:0] = old_data;
        s8[N-1:0]    = strb;
        m64    = merge_bytes(n64, o64, s8);
        merged = m64[8*N-1:0];
    end
endmodule

// File: rtl/axi4_lite_register_responder.sv
// AXI4-Lite responder that fronts a peripheral register bank.
//   aclk, aresetn : clock, synchronous active-low reset
//   axi           : AXI4-Lite slave port (AW/W/B/AR/R)
//   register_in   : current value of every register
//   wr_en, rd_en  : one-cycle one-hot write / read strobes
//   wdata         : strobe-merged write data, valid with wr_en
// Write and read paths are independent FSMs, each with one transaction
// in flight. Every index decodes, so responses are always OKAY.
module axi4_lite_register_responder
    import axi4_lite_register_pkg::*;
#(
    parameter int N  = 4,
    parameter int MW = 3,
    parameter int MI = 2**MW,
    parameter int A  = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi4_lite_if.slave             axi,
    input  logic [MI-1:0][8*N-1:0] register_in,
    output logic [MI-1:0]          wr_en,
    output logic [MI-1:0]          rd_en,
    output logic [8*N-1:0]         wdata
);
    if (!(N == 4 || N == 8)) begin : g_bad_n
        $fatal(1, "axi4_lite_register_responder: N must be 4 or 8");
    end

    localparam int LSB = $clog2(N);

    // Readies stay low for the first cycle after reset release, so a
    // valid presented in the deassertion cycle is not taken.
    logic alive;

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic           aw_held, w_held;
    logic [MW-1:0]  aw_idx;
    logic [8*N-1:0] w_data_h;
    logic [N-1:0]   w_strb_h;
    logic [MW-1:0]  ar_idx;
    logic [8*N-1:0] rdata_q;

    logic awready_c, wready_c, bvalid_c, aw_fire, w_fire;
    logic arready_c, rvalid_c, ar_fire;

    logic [ADDR_MAX-1:0] aw64, ar64;
    logic [IDX_MAX-1:0]  aw_dec, ar_dec;
    logic [8*N-1:0]      merged;

    always_comb begin
        aw64 = '0;
        ar64 = '0;
        aw64[A-1:0] = axi.awaddr;
        ar64[A-1:0] = axi.araddr;
        aw_dec = idx_of(aw64, LSB, MW);
        ar_dec = idx_of(ar64, LSB, MW);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) alive <= 1'b0;
        else          alive <= 1'b1;
    end

    // ---------------- write path ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) wr_state <= WR_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next   = wr_state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        wr_en     = '0;
        case (wr_state)
            WR_IDLE: begin
                awready_c = alive && !aw_held;
                wready_c  = alive && !w_held;
                aw_fire   = axi.awvalid && awready_c;
                w_fire    = axi.wvalid && wready_c;
                if ((aw_held || aw_fire) && (w_held || w_fire)) wr_next = WR_EXEC;
            end
            WR_EXEC: begin
                wr_en[aw_idx] = 1'b1;
                wr_next       = WR_RESP;
            end
            WR_RESP: begin
                bvalid_c = 1'b1;
                if (axi.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data_h <= '0;
            w_strb_h <= '0;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= aw_dec[MW-1:0];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_h <= axi.wdata_axi;
                w_strb_h <= axi.wstrb;
            end
            if (wr_state == WR_RESP && axi.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    axi4_lite_register_wr_merge #(.N(N)) u_merge (
        .new_data (w_data_h),
        .old_data (register_in[aw_idx]),
        .strb     (w_strb_h),
        .merged   (merged)
    );

    // Merged data is only presented alongside the strobe.
    assign wdata = (wr_state == WR_EXEC) ? merged : '0;

    // ---------------- read path ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) rd_state <= RD_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next   = rd_state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        ar_fire   = 1'b0;
        rd_en     = '0;
        case (rd_state)
            RD_IDLE: begin
                arready_c = alive;
                ar_fire   = axi.arvalid && arready_c;
                if (ar_fire) rd_next = RD_EXEC;
            end
            RD_EXEC: begin
                rd_en[ar_idx] = 1'b1;
                rd_next       = RD_RESP;
            end
            RD_RESP: begin
                rvalid_c = 1'b1;
                if (axi.rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // rdata samples register_in during the strobe cycle, so a write to
    // the same register in that cycle is not yet visible.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ar_idx  <= '0;
            rdata_q <= '0;
        end else begin
            if (ar_fire) ar_idx <= ar_dec[MW-1:0];
            if (rd_state == RD_EXEC) rdata_q <= register_in[ar_idx];
        end
    end

    assign axi.awready = awready_c;
    assign axi.wready  = wready_c;
    assign axi.bvalid  = bvalid_c;
    assign axi.bresp   = RESP_OKAY;
    assign axi.arready = arready_c;
    assign axi.rvalid  = rvalid_c;
    assign axi.rresp   = RESP_OKAY;
    assign axi.rdata   = rdata_q;
endmodule

// File: doc/axi4_lite_register_responder.md
Name: axi4_lite_register_responder

Overview:
- AXI4-Lite slave (responder) that terminates a single AXI4-Lite port and drives the register side of an axi4_lite_register_if (register_in, wr_en, rd_en, wdata).
- Decodes the AW and AR addresses to a register index, issues one-cycle wr_en/rd_en strobes, merges WSTRB against the current register value, and returns B and R responses.
- Sits between the AXI4-Lite interconnect and each peripheral's register bank.

Parameters:
- N, 4, data bus width in bytes; only 4 or 8 are legal (simulation $fatal otherwise).
- MW, 3, register index (mux select) width.
- MI, 2**MW, number of registers.
- A, 32, AXI address width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- awaddr  in  A  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata_axi  in  8N  AXI write data.
- wstrb  in  N  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  A  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  8N  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- register_in  in  MI x 8N  current register values.
- wr_en  out  MI  one-hot write strobe.
- rd_en  out  MI  one-hot read strobe.
- wdata  out  8N  merged write data.

Behaviour:
- Reset: aresetn sampled on the rising aclk edge, active low, synchronous.
  - Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, wr_en=0, rd_en=0, bresp=0, rresp=0, rdata=0, wdata=0.
  - Held AW/W flags are cleared and both FSMs go to IDLE.
  - Reset mid-transaction abandons the transaction; no strobe is issued afterwards.
- Index decode: idx = addr[log2(N) +: MW]. Low log2(N) bits and bits above log2(N)+MW are ignored. Every index is valid, so bresp and rresp are always 2'b00 (OKAY).
- Write FSM states: WR_IDLE, WR_EXEC, WR_RESP.
  - WR_IDLE:
    - awready = !aw_held; wready = !w_held (both are 1 on the first cycle after reset release).
    - AW and W are accepted independently, in either order or together; each is captured into a holding register and its held flag is set.
    - When both flags are set (including the cycle they become set), the FSM goes to WR_EXEC on the next edge.
  - WR_EXEC (exactly one cycle):
    - wr_en[idx]=1, all other bits 0.
    - wdata byte k = wstrb_held[k] ? wdata_held byte k : register_in[idx] byte k.
    - awready=wready=0.
    - Next state is WR_RESP.
  - WR_RESP:
    - bvalid=1, held until bready. On the bvalid&bready edge, go to WR_IDLE and clear the held flags.
    - awready and wready stay 0 until IDLE.
  - Latency: AW and W handshake together at cycle T → wr_en at T+1 → bvalid at T+2. Minimum 3 cycles per write.
  - wstrb=0: wr_en still pulses, and wdata equals register_in (idempotent write).
- Read FSM states: RD_IDLE, RD_EXEC, RD_RESP.
  - RD_IDLE: arready=1. On the handshake, capture idx and go to RD_EXEC.
  - RD_EXEC (one cycle): rd_en[idx]=1; rdata is registered from register_in[idx] at the end of this cycle.
  - RD_RESP: rvalid=1 with rdata stable until rready, then go to RD_IDLE.
  - Latency: AR handshake at T → rd_en at T+1 → rvalid at T+2.
- Read and write FSMs are fully independent. A wr_en and rd_en in the same cycle on the same idx is legal; rdata returns the pre-write value, because register_in is sampled before the register updates.
- AXI rules:
  - Ready signals do not depend combinationally on valid.
  - Outputs are held stable under backpressure.
  - At most one outstanding write and one outstanding read.
- Valid in the same cycle as reset deassertion is not accepted, because the readies are 0 in that cycle.

Decomposition:
- Package axi4_lite_register_pkg holds:
  - write and read state enums;
  - RESP_OKAY=2'b00;
  - a function idx_of(addr) for the index decode;
  - a function merge_bytes(new, old, strb) for the strobe merge.
- One sub-module, axi4_lite_register_wr_merge: purely combinational strobe merge, reused by other slaves.
- The read path stays inline.

Test Plan:
- N=4, MW=3. AW addr 0x0C and W 0xDEADBEEF, strb 4'hF in the same cycle, bready=1 → wr_en=8'b0000_1000 for one cycle, wdata=0xDEADBEEF, bvalid two cycles later, bresp=0.
- W at cycle 0, AW addr 0x04 at cycle 3 → wready=0 from cycle 1, wr_en[1] at cycle 4, bvalid at cycle 5.
- register_in[2]=0x11223344, write 0xAABBCCDD strb 4'b0101 to addr 0x08 → wdata=0x11BB33DD.
- AR addr 0x1C with register_in[7]=0xCAFEF00D, rready held low 5 cycles → rd_en[7] one pulse, rvalid stays 1 with rdata=0xCAFEF00D stable, completes when rready=1.
- Simultaneous write and read to idx 5 (old value 0x1, new 0x2) → rdata=0x1. After the write completes, a second read returns 0x2.
- aresetn=0 during WR_RESP with bvalid=1 → bvalid=0 at the next edge, no further wr_en, awready=wready=1 one cycle after aresetn=1.
